controlador_de_interrupcao: RTL and testbench

//  Upstream of the control unit. Drives its intr input and a preemption request.

---
 rtl/controlador_de_interrupcao.sv | 126 ++++++++++++
 tb/tb_controlador_de_interrupcao.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/controlador_de_interrupcao.sv
// Interrupt front end: debounced INSERT-key input request plus the user-mode
// quantum timer that raises the preemption request.
module controlador_de_interrupcao #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned QUANTUM         = 1024,
  parameter int unsigned QW              = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       isIn,
  input  logic       mode,
  input  logic       timerAck,
  output logic       intr,
  output logic       timerIrq,
  output logic [1:0] intc,
  output logic       busy
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] QLAST = QW'(QUANTUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PENDING,
    DB_REL
  } key_state_t;

  key_state_t    state, state_next;
  logic [DW-1:0] dcnt, dcnt_next, dcnt_inc;
  logic          sync1, sync2, ks;
  logic [QW-1:0] qcount;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign ks       = ~sync2;
  assign dcnt_inc = dcnt + DW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  // The IDLE->DB_PRESS edge already counts the first stable sample, so the
  // press leg completes on the incremented value; the release leg counts from
  // the first stable sample inside DB_REL, giving both legs 16 stable samples.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    case (state)
      IDLE: begin
        dcnt_next = '0;
        if (ks) state_next = DB_PRESS;
      end
      DB_PRESS: begin
        if (!ks) begin
          dcnt_next  = '0;
          state_next = IDLE;
        end else if (dcnt_inc == DLAST) begin
          dcnt_next  = '0;
          state_next = PENDING;
        end else begin
          dcnt_next = dcnt_inc;
        end
      end
      PENDING: begin
        dcnt_next = '0;
        if (isIn) state_next = DB_REL;
      end
      DB_REL: begin
        if (ks) begin
          dcnt_next = '0;
        end else if (dcnt == DLAST) begin
          dcnt_next  = '0;
          state_next = IDLE;
        end else begin
          dcnt_next = dcnt_inc;
        end
      end
      default: begin
        dcnt_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Kernel mode has priority over both expiry and acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qcount   <= '0;
      timerIrq <= 1'b0;
    end else if (!mode) begin
      qcount   <= '0;
      timerIrq <= 1'b0;
    end else if (timerIrq) begin
      qcount <= '0;
      if (timerAck) timerIrq <= 1'b0;
    end else if (qcount == QLAST) begin
      qcount   <= '0;
      timerIrq <= 1'b1;
    end else begin
      qcount <= qcount + QW'(1);
    end
  end

  assign intr = (state == PENDING);
  assign busy = (state != IDLE);
  assign intc = {intr, timerIrq};

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Directed bench for controlador_de_interrupcao: vector table plus hand-written
// latency and asynchronous-reset sequences.
module tb_controlador_de_interrupcao;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       isIn;
  logic       mode;
  logic       timerAck;
  logic       intr;
  logic       timerIrq;
  logic [1:0] intc;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  controlador_de_interrupcao #(
    .DEBOUNCE_CYCLES(16),
    .QUANTUM(1024),
    .QW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .isIn(isIn),
    .mode(mode),
    .timerAck(timerAck),
    .intr(intr),
    .timerIrq(timerIrq),
    .intc(intc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        key;
    logic        is_in;
    logic        mode;
    logic        ack;
    int unsigned cycles;
    logic        exp_intr;
    logic        exp_irq;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic k, input logic i, input logic m, input logic a,
                     input int unsigned n, input logic ei, input logic eq, input logic eb);
    vec_t v;
    v.key = k; v.is_in = i; v.mode = m; v.ack = a; v.cycles = n;
    v.exp_intr = ei; v.exp_irq = eq; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ei, input logic eq, input logic eb);
    check({tag, " intr"}, {1'b0, intr}, {1'b0, ei});
    check({tag, " timerIrq"}, {1'b0, timerIrq}, {1'b0, eq});
    check({tag, " intc"}, intc, {ei, eq});
    check({tag, " busy"}, {1'b0, busy}, {1'b0, eb});
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned lat;

    rst = 1'b0; key = 1'b1; isIn = 1'b0; mode = 1'b0; timerAck = 1'b0;

    // key, isIn, mode, ack, cycles, exp intr, irq, busy
    add(0,0,0,0,5,    0,0,1);   // short press
    add(1,0,0,0,3,    0,0,0);   // glitch rejected
    add(0,0,0,0,17,   0,0,1);   // long press
    add(0,0,0,0,1,    1,0,1);   // intr at 18
    add(0,0,0,0,12,   1,0,1);
    add(0,1,0,0,1,    0,0,1);   // consumed at 31
    add(0,0,0,0,9,    0,0,1);   // held: no re-arm
    add(1,0,0,0,17,   0,0,1);
    add(1,0,0,0,1,    0,0,0);   // release debounced
    add(1,0,0,0,2,    0,0,0);
    add(0,0,0,0,18,   1,0,1);   // second pulse
    add(0,1,0,0,1,    0,0,1);
    add(1,0,0,0,15,   0,0,1);   // 15-cycle release too short
    add(0,0,0,0,30,   0,0,1);
    add(1,0,0,0,17,   0,0,1);
    add(1,0,0,0,1,    0,0,0);
    add(0,0,0,0,15,   0,0,1);   // 15-cycle press rejected
    add(1,0,0,0,3,    0,0,0);
    add(1,1,0,0,4,    0,0,0);   // isIn ignored in IDLE
    add(0,0,0,0,16,   0,0,1);   // 16-cycle press accepted
    add(1,0,0,0,2,    1,0,1);
    add(1,0,0,0,10,   1,0,1);   // release does not cancel
    add(1,1,0,0,1,    0,0,1);
    add(1,0,0,0,15,   0,0,1);
    add(1,0,0,0,1,    0,0,0);
    add(0,1,0,0,10,   0,0,1);   // isIn ignored in DB_PRESS
    add(0,0,0,0,8,    1,0,1);
    add(0,1,0,0,1,    0,0,1);
    add(1,0,0,0,18,   0,0,0);
    add(1,0,1,0,1023, 0,0,0);   // quantum
    add(1,0,1,0,1,    0,1,0);
    add(1,0,1,0,5,    0,1,0);   // frozen while pending
    add(1,0,1,1,1,    0,0,0);   // ack
    add(1,0,1,0,1023, 0,0,0);   // restart from 0
    add(1,0,1,0,1,    0,1,0);
    add(1,0,0,0,1,    0,0,0);   // kernel clears
    add(1,0,1,0,1023, 0,0,0);
    add(1,0,0,0,1,    0,0,0);   // mode wins over expiry
    add(1,0,1,0,1023, 0,0,0);
    add(1,0,1,0,1,    0,1,0);
    add(1,0,0,0,1,    0,0,0);
    add(1,0,1,1,1024, 0,1,0);   // ack without irq ignored
    add(1,0,1,1,1,    0,0,0);
    add(1,0,0,0,1,    0,0,0);
    add(0,0,1,0,1024, 1,1,1);   // both requests
    add(0,1,1,1,1,    0,0,1);   // both cleared together
    add(1,0,0,0,20,   0,0,0);

    tick(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(2);

    for (int i = 0; i < vecs.size(); i++) begin
      key = vecs[i].key; isIn = vecs[i].is_in;
      mode = vecs[i].mode; timerAck = vecs[i].ack;
      tick(vecs[i].cycles);
      check_outs($sformatf("row%0d", i), vecs[i].exp_intr, vecs[i].exp_irq, vecs[i].exp_busy);
    end
    key = 1'b1; isIn = 1'b0; mode = 1'b0; timerAck = 1'b0;
    tick(2);

    // press-to-intr latency, bounded wait
    key = 1'b0;
    lat = 0;
    while (intr !== 1'b1 && lat < 64) begin
      tick(1);
      lat++;
    end
    check("latency", (lat == 18) ? 2'b01 : 2'b00, 2'b01);
    isIn = 1'b1;
    tick(1);
    isIn = 1'b0; key = 1'b1;
    tick(20);
    check_outs("after_latency", 1'b0, 1'b0, 1'b0);

    // reset during PENDING with a partly elapsed quantum
    key = 1'b0; mode = 1'b1;
    tick(1000);
    check_outs("pre_reset", 1'b1, 1'b0, 1'b1);
    #3 rst = 1'b0;
    #1 check_outs("async_reset", 1'b0, 1'b0, 1'b0);
    key = 1'b1;
    tick(2);
    #3 rst = 1'b1;
    repeat (1023) @(posedge clk);
    #1 check_outs("post_reset_1023", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("post_reset_1024", 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
